dnn_run_ctrl: RTL and testbench

Run sequencer for the DNN training core. After a start pulse it streams training samples from the sample memory into the DNN, one sample per junction cycle, for a fixed number of epochs. It drives the learning-rate exponent etapos0 on an epoch-based schedule and scores final-epoch predictions by comparing ansL against actL_alln. It sits between the top-level button/UART glue and the DNN instance, and supplies the "finish running" indication.

---
 rtl/dnn_run_ctrl.sv | 133 +++++++++++++
 tb/tb_dnn_run_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dnn_run_ctrl.sv
// Run sequencer for the DNN training core: streams samples from the sample
// memory into the DNN slot by slot for a fixed number of epochs, steps the
// learning-rate exponent on an epoch schedule and scores final-epoch results.
module dnn_run_ctrl #(
    parameter int NUM_SAMPLES  = 1024,
    parameter int SAMPLE_AW    = 10,
    parameter int NUM_EPOCHS   = 4,
    parameter int CYCLE_CLK    = 4,
    parameter int PIPE_SAMPLES = 3,
    parameter int NOUT         = 10,
    parameter int ETA_INIT     = 4,
    parameter int ETA_STEP     = 2,
    parameter int ETA_MAX      = 7,
    parameter int EPW          = 8,
    parameter int CW           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [SAMPLE_AW-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 sample_valid,
    output logic [2:0]           etapos0,
    input  logic [NOUT-1:0]      ansL,
    input  logic [NOUT-1:0]      actL_alln,
    output logic [EPW-1:0]       epoch_cnt,
    output logic [CW-1:0]        correct_cnt,
    output logic                 busy,
    output logic                 done
);

    localparam int FEED  = NUM_EPOCHS * NUM_SAMPLES;
    localparam int TOTAL = FEED + PIPE_SAMPLES;
    localparam int SW    = $clog2(TOTAL + 1);
    localparam int CCW   = $clog2(CYCLE_CLK);

    localparam logic [SW-1:0]        S_FEED    = SW'(FEED);
    localparam logic [SW-1:0]        S_LAST    = SW'(TOTAL - 1);
    // First slot whose scored result belongs to a final-epoch sample.
    localparam logic [SW-1:0]        S_FIN_LO  = SW'((NUM_EPOCHS - 1) * NUM_SAMPLES + PIPE_SAMPLES);
    localparam logic [CCW-1:0]       CC_LAST   = CCW'(CYCLE_CLK - 1);
    localparam logic [CCW-1:0]       CC_RD     = CCW'(0);
    localparam logic [CCW-1:0]       CC_LOAD   = CCW'(1);
    localparam logic [SAMPLE_AW-1:0] ADDR_LAST = SAMPLE_AW'(NUM_SAMPLES - 1);
    localparam logic [2:0]           ETA_I     = 3'(ETA_INIT);
    localparam logic [2:0]           ETA_M     = 3'(ETA_MAX);
    localparam logic [EPW-1:0]       EP_N      = EPW'(NUM_EPOCHS);
    localparam logic [EPW-1:0]       EP_STEP   = EPW'(ETA_STEP);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CCW-1:0] cyc_q;
    logic [SW-1:0]  slot_q;
    logic [EPW-1:0] ep_next;
    logic           in_feed, slot_end, start_run, run_go;
    logic           epoch_end, eta_bump, score;

    assign in_feed   = slot_q < S_FEED;
    assign slot_end  = cyc_q == CC_LAST;
    assign start_run = (state_q != RUN) && start;
    assign run_go    = (state_q == RUN) && !abort;
    // mem_addr tracks the sample index, so its last value marks the epoch end.
    assign epoch_end = slot_end && in_feed && (mem_addr == ADDR_LAST);
    assign ep_next   = epoch_cnt + 1'b1;
    assign eta_bump  = ((ep_next % EP_STEP) == '0) && (ep_next < EP_N);
    assign score     = slot_end && (slot_q >= S_FIN_LO) &&
                       (ansL == actL_alln) && (ansL != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and decoded slot strobes.
    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        done         = 1'b0;
        mem_rd       = 1'b0;
        sample_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy         = 1'b1;
                mem_rd       = in_feed && (cyc_q == CC_RD);
                sample_valid = in_feed && (cyc_q == CC_LOAD);
                if (abort)                           state_d = IDLE;
                else if (slot_end && slot_q == S_LAST) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot timing, sample address, epoch/eta schedule and scoring.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q       <= '0;
            slot_q      <= '0;
            mem_addr    <= '0;
            epoch_cnt   <= '0;
            correct_cnt <= '0;
            etapos0     <= ETA_I;
        end else if (start_run) begin
            cyc_q       <= '0;
            slot_q      <= '0;
            mem_addr    <= '0;
            epoch_cnt   <= '0;
            correct_cnt <= '0;
            etapos0     <= ETA_I;
        end else if (run_go) begin
            cyc_q <= slot_end ? '0 : cyc_q + 1'b1;
            if (slot_end) begin
                slot_q <= slot_q + 1'b1;
                if (in_feed) mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + 1'b1;
            end
            if (epoch_end) begin
                epoch_cnt <= ep_next;
                if (eta_bump) etapos0 <= (etapos0 >= ETA_M) ? ETA_M : etapos0 + 1'b1;
            end
            if (score && (correct_cnt != '1)) correct_cnt <= correct_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dnn_run_ctrl.sv
// Self-checking bench for dnn_run_ctrl: directed run scenarios with random
// answer/prediction patterns, checked each clock against a slot-level model.
module tb_dnn_run_ctrl;

    localparam int NS = 4, AW = 2, NE = 2, CC = 4, PS = 2, NO = 10;
    localparam int EI = 4, ES = 1, EM = 5, EPW = 8, CW = 16;
    localparam int FEED = NE * NS, TOTAL = FEED + PS;

    localparam int M_ONE = 0, M_WIN = 1, M_ZERO = 2, M_RAND = 3;

    logic           clk = 1'b0;
    logic           reset, start, abort;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd, sample_valid, busy, done;
    logic [2:0]     etapos0;
    logic [NO-1:0]  ansL, actL_alln;
    logic [EPW-1:0] epoch_cnt;
    logic [CW-1:0]  correct_cnt;

    dnn_run_ctrl #(
        .NUM_SAMPLES(NS), .SAMPLE_AW(AW), .NUM_EPOCHS(NE), .CYCLE_CLK(CC),
        .PIPE_SAMPLES(PS), .NOUT(NO), .ETA_INIT(EI), .ETA_STEP(ES),
        .ETA_MAX(EM), .EPW(EPW), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .sample_valid(sample_valid),
        .etapos0(etapos0), .ansL(ansL), .actL_alln(actL_alln),
        .epoch_cnt(epoch_cnt), .correct_cnt(correct_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: clocks elapsed in the run, plus the visible results.
    bit m_run, m_done, m_rst;
    int m_k, m_ep, m_cor, m_eta;
    int mode = M_ONE, win_lo = 0, win_hi = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs applied at that edge.
    task automatic model_clk(input bit st, input bit ab, input bit rs);
        int sl, c, j;
        m_rst = rs;
        if (rs) begin
            m_run = 0; m_done = 0; m_k = 0; m_ep = 0; m_cor = 0; m_eta = EI;
        end else if (m_run) begin
            if (ab) m_run = 0;
            else begin
                sl = m_k / CC; c = m_k % CC;
                if (c == CC - 1) begin
                    if (sl < FEED && sl % NS == NS - 1) begin
                        m_ep++;
                        if (m_ep % ES == 0 && m_ep < NE) m_eta = (m_eta + 1 > EM) ? EM : m_eta + 1;
                    end
                    j = sl - PS;
                    if (j >= (NE - 1) * NS && j < FEED && ansL == actL_alln && ansL != 0)
                        m_cor = (m_cor == (1 << CW) - 1) ? m_cor : m_cor + 1;
                    if (sl == TOTAL - 1) begin m_run = 0; m_done = 1; end
                end
                m_k++;
            end
        end else if (st) begin
            m_run = 1; m_done = 0; m_k = 0; m_ep = 0; m_cor = 0; m_eta = EI;
        end
    endtask

    // One clock: drive inputs, clock, update model, compare all outputs.
    task automatic step(input bit st, input bit ab, input bit rs);
        int sl, c;
        bit feed;
        sl = m_run ? m_k / CC : -1;
        start = st; abort = ab; reset = rs;
        case (mode)
            M_ONE:  begin ansL = 10'd1; actL_alln = 10'd1; end
            M_WIN:  begin ansL = 10'd1; actL_alln = (sl >= win_lo && sl <= win_hi) ? 10'd1 : 10'd2; end
            M_ZERO: begin ansL = '0; actL_alln = '0; end
            default: begin
                ansL = 10'd1 << $urandom_range(0, NO - 1);
                actL_alln = ($urandom_range(0, 2) != 0) ? ansL : 10'd1 << $urandom_range(0, NO - 1);
                if ($urandom_range(0, 7) == 0) begin ansL = '0; actL_alln = '0; end
            end
        endcase
        @(posedge clk);
        model_clk(st, ab, rs);
        #1;
        start = 0; abort = 0; reset = 0;
        sl = m_k / CC; c = m_k % CC;
        feed = m_run && sl < FEED;
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("mem_rd", 32'(mem_rd), 32'(feed && c == 0));
        chk("sample_valid", 32'(sample_valid), 32'(feed && c == 1));
        chk("etapos0", 32'(etapos0), 32'(m_eta));
        chk("epoch_cnt", 32'(epoch_cnt), 32'(m_ep));
        chk("correct_cnt", 32'(correct_cnt), 32'(m_cor));
        if (feed || m_rst) chk("mem_addr", 32'(mem_addr), m_rst ? 32'd0 : 32'(sl % NS));
    endtask

    // Full run from start; checks pulse count/spacing, address order and timing of done.
    task automatic full_run(input bit poke_start, input int exp_cor);
        int pulses, first, last_i;
        bit spacing_ok;
        pulses = 0; first = -1; last_i = -100; spacing_ok = 1;
        step(1, 0, 0);
        for (int i = 1; i <= 4 * TOTAL; i++) begin
            if (i == 39) chk("done_early", 32'(done), 32'd0);
            step(poke_start && (i % 7 == 3), 0, 0);
            if (sample_valid) begin
                chk("addr_at_load", 32'(mem_addr), 32'(pulses % NS));
                if (first < 0) first = i;
                else if (i - last_i != CC) spacing_ok = 0;
                last_i = i;
                pulses++;
            end
        end
        chk("pulses", 32'(pulses), 32'd8);
        chk("first_pulse", 32'(first), 32'd1);
        chk("spacing", 32'(spacing_ok), 32'd1);
        chk("done_t41", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("epoch_end", 32'(epoch_cnt), 32'd2);
        chk("eta_end", 32'(etapos0), 32'd5);
        chk("cor_end", 32'(correct_cnt), 32'(exp_cor));
    endtask

    task automatic run_to(input int sl, input int c);
        int n = 0;
        while (!(m_run && m_k / CC == sl && m_k % CC == c) && n < 100) begin
            step(0, 0, 0); n++;
        end
        chk("run_to_bound", 32'(n < 100), 32'd1);
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; ansL = '0; actL_alln = '0;
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 0);             // abort while idle is ignored
        step(0, 0, 0);

        // Basic run, all-ones patterns; then restart from DONE with ignored start pokes.
        mode = M_ONE;
        full_run(0, 4);
        step(0, 0, 0);
        full_run(1, 4);

        // Scoring window: epoch-0 results only, final-epoch only, zero answers.
        mode = M_WIN; win_lo = 2; win_hi = 5;
        full_run(0, 0);
        win_lo = 6; win_hi = 9;
        full_run(0, 4);
        mode = M_ZERO;
        full_run(0, 0);

        // Abort in slot 5, then restart.
        mode = M_ONE;
        step(1, 0, 0);
        run_to(5, 1);
        step(0, 1, 0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_epoch", 32'(epoch_cnt), 32'd1);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("restart_addr", 32'(mem_addr), 32'd0);
        chk("restart_epoch", 32'(epoch_cnt), 32'd0);

        // abort beats start in RUN; start beats abort in IDLE.
        run_to(2, 0);
        step(1, 1, 0);
        chk("abort_wins", 32'(busy), 32'd0);
        step(1, 1, 0);
        chk("start_wins", 32'(busy), 32'd1);

        // Reset mid-run in slot 3.
        run_to(3, 2);
        step(0, 0, 1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eta", 32'(etapos0), 32'd4);
        chk("rst_addr", 32'(mem_addr), 32'd0);

        // Randomized patterns, with random extra idle gaps between runs.
        mode = M_RAND;
        for (int r = 0; r < 4; r++) begin
            step(1, 0, 0);
            for (int i = 0; i < 4 * TOTAL + 1; i++) step(0, 0, 0);
            chk("rand_done", 32'(done), 32'd1);
            repeat ($urandom_range(0, 3)) step(0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
